// File: rtl/aurora_hls_monitor_pkg.sv
// Shared definitions for the link-monitor snapshot path: counter width,
// default counter count, fixed counter ordering and the sequencer states.
package aurora_hls_monitor_pkg;

  localparam int CNT_W       = 32;
  localparam int NUM_CNT_DEF = 15;

  // Position of each live counter inside the flattened cnt_in bus
  localparam int FIFO_RX_OVF     = 0;
  localparam int GT_NOT_READY_0  = 1;
  localparam int GT_NOT_READY_1  = 2;
  localparam int GT_NOT_READY_2  = 3;
  localparam int GT_NOT_READY_3  = 4;
  localparam int LINE_DOWN_0     = 5;
  localparam int LINE_DOWN_1     = 6;
  localparam int LINE_DOWN_2     = 7;
  localparam int LINE_DOWN_3     = 8;
  localparam int PLL_NOT_LOCKED  = 9;
  localparam int MMCM_NOT_LOCKED = 10;
  localparam int HARD_ERR        = 11;
  localparam int SOFT_ERR        = 12;
  localparam int CHANNEL_DOWN    = 13;
  localparam int FIFO_TX_OVF     = 14;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } snap_state_e;

endpackage

// File: rtl/aurora_hls_snapshot_bank.sv
// Capture register array for one counter snapshot plus the beat read mux.
// With SNAPSHOT_DELTA_EN defined, a second bank keeps the previous completed
// snapshot and the read port returns the modular difference instead.
module aurora_hls_snapshot_bank
  import aurora_hls_monitor_pkg::*;
#(
  parameter int NUM_CNT = NUM_CNT_DEF,
  parameter int IDX_W   = 8
) (
  input  logic                     clk_u,
  input  logic                     rst,
  input  logic                     capture,
  input  logic                     commit,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [CNT_W-1:0]         rd_data
);

  logic [CNT_W-1:0] snap [NUM_CNT];

  // Latch every live counter on the same edge so a snapshot is never torn
  always_ff @(posedge clk_u) begin
    if (rst) begin
      for (int k = 0; k < NUM_CNT; k++) snap[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < NUM_CNT; k++) snap[k] <= cnt_in[k*CNT_W +: CNT_W];
    end
  end

`ifdef SNAPSHOT_DELTA_EN
  logic [CNT_W-1:0] prev [NUM_CNT];

  // Only a fully delivered snapshot becomes the new baseline
  always_ff @(posedge clk_u) begin
    if (rst) begin
      for (int k = 0; k < NUM_CNT; k++) prev[k] <= '0;
    end else if (commit) begin
      for (int k = 0; k < NUM_CNT; k++) prev[k] <= snap[k];
    end
  end

  // Select the indexed word as a mod-2^32 delta against the baseline
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (rd_idx == IDX_W'(k)) rd_data = snap[k] - prev[k];
    end
  end
`else
  logic unused_commit;
  assign unused_commit = commit;

  // Select the indexed absolute word
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (rd_idx == IDX_W'(k)) rd_data = snap[k];
    end
  end
`endif

endmodule

// File: rtl/aurora_hls_monitor_snapshot.sv
// Atomic snapshot of the clk_u link-monitor counters, streamed one word per
// beat on a valid/ready interface. Optional macro SNAPSHOT_DELTA_EN switches
// the stream from absolute values to deltas against the previous snapshot.
module aurora_hls_monitor_snapshot
  import aurora_hls_monitor_pkg::*;
#(
  parameter int NUM_CNT = NUM_CNT_DEF,
  parameter int IDX_W   = 8
) (
  input  logic                     clk_u,
  input  logic                     rst,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
  input  logic                     snap_req,
  output logic                     busy,
  output logic [CNT_W-1:0]         m_tdata,
  output logic [IDX_W-1:0]         m_tuser,
  output logic                     m_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [31:0]              snap_count,
  output logic [31:0]              dropped_req_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

  snap_state_e      state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             capture;
  logic             commit;
  logic [CNT_W-1:0] rd_data;

  assign capture = (state == ST_IDLE) && snap_req;
  assign commit  = (state == ST_STREAM) && m_tready && m_tlast;
  assign idx_nxt = idx + IDX_W'(1);

  assign m_tuser = idx;
  // Idle data is forced to zero so the bus never shows stale snapshot words
  assign m_tdata = m_tvalid ? rd_data : '0;

  aurora_hls_snapshot_bank #(
    .NUM_CNT (NUM_CNT),
    .IDX_W   (IDX_W)
  ) u_bank (
    .clk_u   (clk_u),
    .rst     (rst),
    .capture (capture),
    .commit  (commit),
    .cnt_in  (cnt_in),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );

  // Capture/stream sequencer with registered handshake outputs and event counters
  always_ff @(posedge clk_u) begin
    if (rst) begin
      state             <= ST_IDLE;
      idx               <= '0;
      busy              <= 1'b0;
      m_tvalid          <= 1'b0;
      m_tlast           <= 1'b0;
      snap_count        <= '0;
      dropped_req_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (snap_req) begin
            state    <= ST_STREAM;
            idx      <= '0;
            busy     <= 1'b1;
            m_tvalid <= 1'b1;
            m_tlast  <= (LAST_IDX == '0);
          end
        end
        ST_STREAM: begin
          // busy stays high through the last-beat edge, so a request there is dropped too
          if (snap_req) dropped_req_count <= dropped_req_count + 32'd1;
          if (m_tready) begin
            if (m_tlast) begin
              state      <= ST_IDLE;
              idx        <= '0;
              busy       <= 1'b0;
              m_tvalid   <= 1'b0;
              m_tlast    <= 1'b0;
              snap_count <= snap_count + 32'd1;
            end else begin
              idx     <= idx_nxt;
              m_tlast <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_hls_monitor_snapshot.sv
// Bench for aurora_hls_monitor_snapshot: a table-driven first snapshot,
// hand-written corner sequences, and a randomized run against a
// transaction-level model (captured word list, beat counter, event counts).
// Honours SNAPSHOT_DELTA_EN when the bench is built with it.
module tb_aurora_hls_monitor_snapshot;
  import aurora_hls_monitor_pkg::*;

  localparam int N  = 15;
  localparam int IW = 8;
`ifdef SNAPSHOT_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  logic            clk_u = 1'b0;
  logic            rst   = 1'b1;
  logic [N*32-1:0] cnt_in = '0;
  logic            snap_req = 1'b0;
  logic            m_tready = 1'b0;
  logic            busy, m_tlast, m_tvalid;
  logic [31:0]     m_tdata, snap_count, dropped_req_count;
  logic [IW-1:0]   m_tuser;

  logic        req1 = 1'b0, rdy1 = 1'b1;
  logic [31:0] cnt1 = '0;
  logic        busy1, tlast1, tvalid1;
  logic [31:0] tdata1, snaps1, drops1;
  logic [0:0]  tuser1;

  always #5 clk_u = ~clk_u;

  aurora_hls_monitor_snapshot #(.NUM_CNT(N), .IDX_W(IW)) dut (
    .clk_u(clk_u), .rst(rst), .cnt_in(cnt_in), .snap_req(snap_req), .busy(busy),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .snap_count(snap_count), .dropped_req_count(dropped_req_count)
  );

  aurora_hls_monitor_snapshot #(.NUM_CNT(1), .IDX_W(1)) dut1 (
    .clk_u(clk_u), .rst(rst), .cnt_in(cnt1), .snap_req(req1), .busy(busy1),
    .m_tdata(tdata1), .m_tuser(tuser1), .m_tlast(tlast1), .m_tvalid(tvalid1),
    .m_tready(rdy1), .snap_count(snaps1), .dropped_req_count(drops1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one outstanding snapshot, described by its word list
  logic [31:0] cap_raw [N];
  logic [31:0] prev_m  [N];
  logic [31:0] exp_w   [N];
  bit          active;
  int          beat;
  logic [31:0] exp_snaps, exp_drops;
  logic [31:0] beat0_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    active    = 1'b0;
    beat      = 0;
    exp_snaps = '0;
    exp_drops = '0;
    for (int k = 0; k < N; k++) prev_m[k] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    snap_req = 1'b0;
    req1 = 1'b0;
    @(posedge clk_u);
    @(negedge clk_u);
    rst = 1'b0;
    model_clear();
    check1("rst_tvalid", m_tvalid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_tlast", m_tlast, 1'b0);
    check("rst_tdata", m_tdata, 32'h0);
    check("rst_tuser", 32'(m_tuser), 32'h0);
    check("rst_snap_count", snap_count, 32'h0);
    check("rst_dropped", dropped_req_count, 32'h0);
  endtask

  // One clock: drive inputs, check the visible beat, advance the model, check counters
  task automatic cycle(input bit req, input bit rdy);
    bit was_active;
    snap_req = req;
    m_tready = rdy;
    was_active = active;
    check1("tvalid", m_tvalid, was_active);
    if (was_active) begin
      check("tdata", m_tdata, exp_w[beat]);
      check("tuser", 32'(m_tuser), 32'(beat));
      check1("tlast", m_tlast, beat == N - 1);
      if (beat == 0) beat0_seen = m_tdata;
    end
    if (req) begin
      if (was_active) exp_drops++;
      else begin
        for (int k = 0; k < N; k++) begin
          cap_raw[k] = cnt_in[k*32 +: 32];
          exp_w[k]   = cap_raw[k] - (DELTA ? prev_m[k] : 32'd0);
        end
        active = 1'b1;
        beat   = 0;
      end
    end
    if (was_active && rdy) begin
      beat++;
      if (beat == N) begin
        active = 1'b0;
        beat   = 0;
        exp_snaps++;
        prev_m = cap_raw;
      end
    end
    @(posedge clk_u);
    @(negedge clk_u);
    snap_req = 1'b0;
    check1("busy", busy, active);
    check("snap_count", snap_count, exp_snaps);
    check("dropped", dropped_req_count, exp_drops);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && active; i++) cycle(1'b0, 1'b1);
    check1("drain_busy", busy, 1'b0);
  endtask

  typedef struct {
    bit          req;
    logic        busy;
    logic        tvalid;
    logic [7:0]  tuser;
    logic        tlast;
    logic [31:0] tdata;
  } vec_t;

  vec_t tbl [N+1];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] first_b0, second_b0;

    for (int k = 0; k < N; k++)
      tbl[k] = '{req: (k == 0), busy: 1'b1, tvalid: 1'b1, tuser: 8'(k),
                 tlast: (k == N - 1), tdata: 32'(k + 100)};
    tbl[N] = '{req: 1'b0, busy: 1'b0, tvalid: 1'b0, tuser: 8'd0, tlast: 1'b0, tdata: 32'd0};

    @(negedge clk_u);
    do_reset();

    // NUM_CNT=1 instance: single beat carries tlast
    cnt1 = 32'hDEAD_BEEF;
    req1 = 1'b1;
    rdy1 = 1'b0;
    @(posedge clk_u);
    @(negedge clk_u);
    req1 = 1'b0;
    cnt1 = 32'h1234_5678;
    check1("n1_tvalid", tvalid1, 1'b1);
    check1("n1_tlast", tlast1, 1'b1);
    check("n1_tuser", 32'(tuser1), 32'd0);
    check("n1_tdata", tdata1, 32'hDEAD_BEEF);
    check1("n1_busy", busy1, 1'b1);
    rdy1 = 1'b1;
    @(posedge clk_u);
    @(negedge clk_u);
    check1("n1_tvalid_after", tvalid1, 1'b0);
    check1("n1_busy_after", busy1, 1'b0);
    check("n1_snap_count", snaps1, 32'd1);
    check("n1_dropped", drops1, 32'd0);

    // Table: first snapshot of k+100 at full throughput
    for (int k = 0; k < N; k++) cnt_in[k*32 +: 32] = 32'(k + 100);
    m_tready = 1'b1;
    for (int i = 0; i <= N; i++) begin
      snap_req = tbl[i].req;
      @(posedge clk_u);
      @(negedge clk_u);
      snap_req = 1'b0;
      check1("t1_busy", busy, tbl[i].busy);
      check1("t1_tvalid", m_tvalid, tbl[i].tvalid);
      check("t1_tuser", 32'(m_tuser), 32'(tbl[i].tuser));
      check1("t1_tlast", m_tlast, tbl[i].tlast);
      check("t1_tdata", m_tdata, tbl[i].tdata);
    end
    check("t1_snap_count", snap_count, 32'd1);

    // Live counters change while streaming with toggling ready
    do_reset();
    for (int k = 0; k < N; k++) cnt_in[k*32 +: 32] = $urandom;
    cycle(1'b1, 1'b1);
    for (int k = 0; k < N; k++) cnt_in[k*32 +: 32] = 32'hFFFF_FFFF;
    for (int i = 0; i < 80 && active; i++) cycle(1'b0, (i % 2) == 0);
    check1("t2_busy", busy, 1'b0);
    check("t2_snap_count", snap_count, 32'd1);

    // Requests at beat 3 and at the last-beat handshake are dropped
    do_reset();
    for (int k = 0; k < N; k++) cnt_in[k*32 +: 32] = $urandom;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 40 && active; i++) cycle(beat == 3 || beat == N - 1, 1'b1);
    check("t3_dropped", dropped_req_count, 32'd2);
    check("t3_snap_count", snap_count, 32'd1);
    cycle(1'b0, 1'b1);
    check1("t3_no_queued", m_tvalid, 1'b0);

    // Reset at beat 7 aborts, then a fresh snapshot starts at index 0
    do_reset();
    for (int k = 0; k < N; k++) cnt_in[k*32 +: 32] = $urandom;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 20 && beat < 7; i++) cycle(1'b0, 1'b1);
    check("t4_at_beat7", 32'(m_tuser), 32'd7);
    do_reset();
    for (int k = 0; k < N; k++) cnt_in[k*32 +: 32] = $urandom;
    cycle(1'b1, 1'b1);
    drain();
    check("t4_snap_count", snap_count, 32'd1);

    // Counter wrap: two snapshots of counter 0
    do_reset();
    for (int k = 0; k < N; k++) cnt_in[k*32 +: 32] = $urandom;
    cnt_in[31:0] = 32'hFFFF_FFF0;
    cycle(1'b1, 1'b1);
    drain();
    first_b0 = beat0_seen;
    cnt_in[31:0] = 32'h0000_0010;
    cycle(1'b1, 1'b1);
    drain();
    second_b0 = beat0_seen;
    check("t5_first_beat0", first_b0, 32'hFFFF_FFF0);
`ifdef SNAPSHOT_DELTA_EN
    check("t5_second_beat0", second_b0, 32'h0000_0020);
`else
    check("t5_second_beat0", second_b0, 32'h0000_0010);
`endif

    // Randomized traffic against the model, with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) cnt_in[k*32 +: 32] = $urandom;
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aurora_hls_monitor_snapshot.md
Name: aurora_hls_monitor_snapshot

Overview:
Downstream consumer of the link monitor's clk_u-domain counters. Takes an atomic snapshot of all counters on request and streams them out one 32-bit word per beat over a valid/ready stream, for the host-facing status path.
Guarantees all words of one snapshot come from the same clk_u cycle, so a host never sees torn counter sets.

Parameters:
NUM_CNT, 15, number of 32-bit counters captured; range 1..256.
IDX_W, 8, width of the beat index on m_tuser; must satisfy 2^IDX_W >= NUM_CNT.

Ports:
clk_u  in  1  link user clock; all logic in this domain.
rst  in  1  reset, synchronous, active-high.
cnt_in  in  NUM_CNT*32  flattened live counters; counter k at bits [32k+31:32k], order fixed by the package.
snap_req  in  1  single-cycle capture request.
busy  out  1  high from capture until the last beat handshakes.
m_tdata  out  32  counter word.
m_tuser  out  IDX_W  counter index of the current beat.
m_tlast  out  1  high on the beat with index NUM_CNT-1.
m_tvalid  out  1  stream valid.
m_tready  in  1  stream ready.
snap_count  out  32  completed snapshots; wraps mod 2^32.
dropped_req_count  out  32  snap_req pulses ignored while busy; wraps mod 2^32.

Behaviour:
- Reset values: busy=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tuser=0, snap_count=0, dropped_req_count=0. All capture registers are cleared to 0.
- FSM states:
  - IDLE: busy=0, m_tvalid=0. On an edge with snap_req=1, all NUM_CNT words of cnt_in are captured at that edge and the FSM goes to STREAM with idx=0.
  - STREAM: busy=1, m_tvalid=1, m_tdata=snap[idx], m_tuser=idx, m_tlast=(idx==NUM_CNT-1).
- Latency: first beat is valid on the cycle after the snap_req edge.
- Handshake rules:
  - A beat transfers on m_tvalid && m_tready.
  - m_tdata, m_tuser and m_tlast are held stable while m_tvalid && !m_tready.
  - m_tvalid never drops mid-snapshot except on rst.
  - On transfer: idx increments. If m_tlast was set, the FSM returns to IDLE and snap_count increments on that edge.
  - Full throughput: one beat per cycle while m_tready=1. A NUM_CNT=15 snapshot takes 15 cycles minimum.
- snap_req while busy=1: ignored; dropped_req_count increments. This includes the cycle of the last-beat handshake, since busy is still 1 then. No queuing.
- snap_req held high for several cycles in IDLE: only the first cycle captures. Later cycles count as dropped.
- NUM_CNT=1: the first beat has m_tlast=1.
- rst mid-STREAM: aborts at the next edge. No further beats; snap_count does not increment for the partial snapshot.
- Live counters keep changing during STREAM; the output reflects only captured values.

Optional Feature:
SNAPSHOT_DELTA_EN
- Defined:
  - A prev[] bank holds the previous capture.
  - m_tdata = snap[idx] - prev[idx] mod 2^32; wrap-around of the source counter yields the correct modular delta.
  - prev[] is updated from snap[] when a snapshot completes (last-beat handshake).
  - An aborted snapshot leaves prev unchanged. prev resets to 0, so the first snapshot equals the absolute values.
- Undefined: absolute values; no prev bank is synthesised.

Decomposition:
- Shared package aurora_hls_monitor_pkg: NUM_CNT default; counter index constants (FIFO_RX_OVF=0, GT_NOT_READY_0..3=1..4, LINE_DOWN_0..3=5..8, PLL_NOT_LOCKED=9, MMCM_NOT_LOCKED=10, HARD_ERR=11, SOFT_ERR=12, CHANNEL_DOWN=13, FIFO_TX_OVF=14); CNT_W=32.
- One sub-module: aurora_hls_snapshot_bank, the capture register array plus index read mux (and the prev bank/subtractor under SNAPSHOT_DELTA_EN). The FSM and handshake stay in the top.

Test Plan:
1. After rst, cnt_in[k]=k+100 for all k, pulse snap_req, m_tready=1 -> 15 consecutive beats: tdata 100..114, tuser 0..14, tlast only on beat 14; snap_count=1; busy low the cycle after.
2. Capture, then change all cnt_in to 0xFFFFFFFF during streaming, with m_tready toggling 1/0 -> output still the captured values; data stable while ready=0; no beat lost or duplicated.
3. Pulse snap_req at beats 3 and 14 (the last-beat handshake cycle) -> dropped_req_count=2, single snapshot delivered, snap_count=1.
4. Assert rst at beat 7 -> m_tvalid=0 from the next cycle; snap_count=0. A new snap_req then delivers a full 15-beat snapshot starting at tuser=0.
5. SNAPSHOT_DELTA_EN defined: snapshot with cnt[0]=0xFFFFFFF0, then a second with cnt[0]=0x10 -> beat 0 reads 0xFFFFFFF0 then 0x20.
6. NUM_CNT=1: snap_req with cnt_in=0xDEADBEEF -> one beat, tlast=1, tuser=0, snap_count=1.
